// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int DATA_SIZE     = 8;
    localparam int FRAME_TICKS   = 10;
    localparam int TIMEOUT_TICKS = 32;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        WAIT_CLR  = 2'd1,
        WAIT_DONE = 2'd2,
        STOP      = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first set request above ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [2:0]         winner_idx,
    output logic               valid
);

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int idx;
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner_idx  = 3'(idx);
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Optional watchdog on the frame wait enabled by UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STOP_TICKS = 1
) (
    input  logic                           s_tick,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [DATA_SIZE*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [DATA_SIZE-1:0]           tx_data,
    output logic                           transmission,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [2:0]                     active_id,
    output logic                           err
);

    localparam logic [3:0] STOP_LAST = 4'(STOP_TICKS - 1);
    localparam logic [2:0] PTR_INIT  = 3'(NUM_REQ - 1);

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [DATA_SIZE-1:0]   tx_data_q, tx_data_d;
    logic                   trans_q, trans_d;
    logic                   busy_q, busy_d;
    logic [2:0]             active_id_q, active_id_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [3:0]             stop_cnt_q, stop_cnt_d;

    logic [DATA_SIZE-1:0]   req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [2:0]             pick_idx;
    logic                   pick_valid;
    logic [DATA_SIZE-1:0]   pick_byte;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*DATA_SIZE +: DATA_SIZE];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // One-hot mux avoids indexing the byte array with a wider-than-needed index.
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) pick_byte = pick_byte | req_bytes[i];
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [5:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        tx_data_d   = tx_data_q;
        trans_d     = 1'b0;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        ptr_d       = ptr_q;
        stop_cnt_d  = stop_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            ARB: begin
                if (pick_valid) begin
                    tx_data_d   = pick_byte;
                    active_id_d = pick_idx;
                    grant_d     = pick_onehot;
                    trans_d     = 1'b1;
                    busy_d      = 1'b1;
                    ptr_d       = pick_idx;
                    state_d     = WAIT_CLR;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end
            end
            // A done still high from the previous frame must drop before we wait for ours.
            WAIT_CLR: begin
                if (!tx_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d    = STOP;
                    stop_cnt_d = '0;
                end
            end
            STOP: begin
                if (stop_cnt_q == STOP_LAST) begin
                    state_d = ARB;
                    busy_d  = 1'b0;
                end else begin
                    stop_cnt_d = stop_cnt_q + 4'd1;
                end
            end
            default: state_d = ARB;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (state_q == WAIT_CLR || state_q == WAIT_DONE) begin
            if (wd_q == 6'(TIMEOUT_TICKS - 1)) begin
                err_d      = 1'b1;
                state_d    = STOP;
                stop_cnt_d = '0;
            end else begin
                wd_d = wd_q + 6'd1;
            end
        end
`endif
    end

    always_ff @(posedge s_tick or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            grant_q     <= '0;
            tx_data_q   <= '0;
            trans_q     <= 1'b0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            ptr_q       <= PTR_INIT;
            stop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            trans_q     <= trans_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            ptr_q       <= ptr_d;
            stop_cnt_q  <= stop_cnt_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge s_tick or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign grant        = grant_q;
    assign tx_data      = tx_data_q;
    assign transmission = trans_q;
    assign busy         = busy_q;
    assign active_id    = active_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: round-robin reference model plus a
// behavioural uart_tx stand-in that raises tx_done 9 ticks after seeing the start pulse.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           s_tick = 1'b0;
    logic           reset  = 1'b0;
    logic [N-1:0]   req    = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           transmission;
    logic           tx_done;
    logic           busy;
    logic [2:0]     active_id;
    logic           err;

    logic [N-1:0]   req4 = '0;
    logic [8*N-1:0] req_data4 = '0;
    logic [N-1:0]   grant4;
    logic [7:0]     tx_data4;
    logic           transmission4;
    logic           tx_done4;
    logic           busy4;
    logic [2:0]     active_id4;
    logic           err4;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ptr_m;
    int ptr4_m;
    logic stall = 1'b0;
    int tx_cnt, tx_cnt4;

    always #5 s_tick = ~s_tick;
    always @(posedge s_tick) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(N), .STOP_TICKS(1)) dut (
        .s_tick(s_tick), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .tx_data(tx_data), .transmission(transmission),
        .tx_done(tx_done), .busy(busy), .active_id(active_id), .err(err)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .STOP_TICKS(4)) dut4 (
        .s_tick(s_tick), .reset(reset), .req(req4), .req_data(req_data4),
        .grant(grant4), .tx_data(tx_data4), .transmission(transmission4),
        .tx_done(tx_done4), .busy(busy4), .active_id(active_id4), .err(err4)
    );

    // Transmitter stand-ins: done rises at start+9 and stays high until the next start.
    always @(posedge s_tick or negedge reset) begin
        if (!reset) begin
            tx_cnt  <= 0;
            tx_done <= 1'b0;
        end else if (transmission) begin
            tx_cnt  <= 1;
            tx_done <= 1'b0;
        end else if (tx_cnt != 0 && !stall) begin
            if (tx_cnt == 9) begin
                tx_done <= 1'b1;
                tx_cnt  <= 0;
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end
    end

    always @(posedge s_tick or negedge reset) begin
        if (!reset) begin
            tx_cnt4  <= 0;
            tx_done4 <= 1'b0;
        end else if (transmission4) begin
            tx_cnt4  <= 1;
            tx_done4 <= 1'b0;
        end else if (tx_cnt4 != 0) begin
            if (tx_cnt4 == 9) begin
                tx_done4 <= 1'b1;
                tx_cnt4  <= 0;
            end else begin
                tx_cnt4 <= tx_cnt4 + 1;
            end
        end
    end

    wire logic [16:0] obs_vec = {grant, tx_data, transmission, busy, active_id};

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int off = 1; off <= N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*N-1:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    function automatic logic [16:0] exp_vec(input int id, input logic [7:0] b);
        logic [N-1:0] oh;
        oh = '0;
        if (id >= 0) oh[id] = 1'b1;
        return {oh, b, 1'b1, 1'b1, 3'(id)};
    endfunction

    task automatic tick();
        @(negedge s_tick);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        req4  = '0;
        stall = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        ptr_m  = N - 1;
        ptr4_m = N - 1;
        tick();
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: no grant within %0d ticks (req=%b)", budget, req);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        if (!idle) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy still %b after 60 ticks", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({grant, tx_data, transmission, busy, active_id, err} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {grant, tx_data, transmission, busy, active_id, err});
        end
        $display("reset: outputs=%h", {grant, tx_data, transmission, busy, active_id, err});
    endtask

    task automatic test_single();
        bit ok;
        int k;
        bit bad;
        req_data = {$urandom, $urandom};
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        wait_grant(5, ok);
        k = cyc;
        vectors++;
        if (obs_vec !== exp_vec(2, 8'hA5)) begin
            miscompares++;
            $display("FAIL single_grant: got %h want %h", obs_vec, exp_vec(2, 8'hA5));
        end
        ptr_m = 2;
        req = '0;
        bad = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (transmission !== 1'b0 || grant !== '0 || tx_data !== 8'hA5 || busy !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL single_frame_hold: outputs changed during frame (last %h)", obs_vec);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || cyc - k != 12) begin
            miscompares++;
            $display("FAIL single_return_arb: busy=%b at +%0d, want 0 at +12", busy, cyc - k);
        end
        $display("single: grant at %0d byte A5, idle at +%0d", k, cyc - k);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int last, exp;
        do_reset();
        req_data = 32'h44332211;
        req = 4'b1111;
        last = -1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(30, ok);
            exp = rr_pick(req, ptr_m);
            vectors++;
            if (obs_vec !== exp_vec(exp, byte_of(req_data, exp))) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: got %h want %h", n, obs_vec, exp_vec(exp, byte_of(req_data, exp)));
            end
            if (last >= 0) begin
                vectors++;
                if (cyc - last != 13) begin
                    miscompares++;
                    $display("FAIL b2b_period%0d: got %0d want 13", n, cyc - last);
                end
            end
            $display("b2b: grant id=%0d byte=%h period=%0d", active_id, tx_data, (last >= 0) ? cyc - last : 0);
            last = cyc;
            ptr_m = exp;
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_fairness();
        bit ok;
        int exp;
        req_data = {$urandom};
        req = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            wait_grant(30, ok);
            exp = rr_pick(req, ptr_m);
            vectors++;
            if (obs_vec !== exp_vec(exp, byte_of(req_data, exp))) begin
                miscompares++;
                $display("FAIL fair_grant%0d: got %h want %h", n, obs_vec, exp_vec(exp, byte_of(req_data, exp)));
            end
            $display("fair: grant id=%0d req=%b", active_id, req);
            ptr_m = exp;
            if (n == 0) begin
                // Requester 0 joins mid-frame; requester 2 asserts then withdraws before ARB.
                repeat (3) tick();
                req[0] = 1'b1;
                req[2] = 1'b1;
                repeat (2) tick();
                req[2] = 1'b0;
            end
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_random();
        bit ok;
        int exp, last, set_cyc;
        bit pending;
        logic [N-1:0] add, drop;
        req = N'($urandom_range(1, (1 << N) - 1));
        req_data = {$urandom};
        pending = 1'b0;
        set_cyc = cyc;
        last = 0;
        for (int n = 0; n < 30; n++) begin
            wait_grant(40, ok);
            exp = rr_pick(req, ptr_m);
            vectors++;
            if (obs_vec !== exp_vec(exp, byte_of(req_data, exp))) begin
                miscompares++;
                $display("FAIL rand_grant%0d: got %h want %h req=%b", n, obs_vec, exp_vec(exp, byte_of(req_data, exp)), req);
            end
            vectors++;
            if (pending ? (cyc - last != 13) : (cyc - set_cyc != 1)) begin
                miscompares++;
                $display("FAIL rand_timing%0d: got %0d want %0d", n, pending ? cyc - last : cyc - set_cyc, pending ? 13 : 1);
            end
            $display("rand: grant id=%0d byte=%h req=%b", active_id, tx_data, req);
            last = cyc;
            ptr_m = exp;
            add  = N'($urandom) & ~req;
            drop = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                req[exp] = 1'b0;
            end else begin
                req_data[8*exp +: 8] = 8'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (add[i]) req_data[8*i +: 8] = 8'($urandom);
            end
            req = (req | add) & ~drop;
            pending = (req != '0);
            if (!pending) begin
                repeat ($urandom_range(14, 20)) tick();
                req = N'($urandom_range(1, (1 << N) - 1));
                req_data = {$urandom};
                set_cyc = cyc;
            end
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int exp;
        req_data = {$urandom};
        req = 4'b0010;
        wait_grant(5, ok);
        req = '0;
        repeat (6) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_busy_before: got %b want 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({grant, tx_data, transmission, busy, active_id, err} !== 18'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got %h want 0", {grant, tx_data, transmission, busy, active_id, err});
        end
        $display("midreset: outputs during reset=%h", {grant, tx_data, transmission, busy, active_id, err});
        tick();
        reset = 1'b1;
        ptr_m  = N - 1;
        ptr4_m = N - 1;
        req_data = {$urandom};
        req = 4'b1111;
        wait_grant(5, ok);
        exp = rr_pick(req, ptr_m);
        vectors++;
        if (obs_vec !== exp_vec(exp, byte_of(req_data, exp)) || exp != 0) begin
            miscompares++;
            $display("FAIL midreset_first: got %h want %h", obs_vec, exp_vec(0, byte_of(req_data, 0)));
        end
        ptr_m = exp;
        req = '0;
        wait_idle();
    endtask

    task automatic test_stop4();
        int last, exp;
        bit ok;
        req_data4 = {$urandom};
        req4 = 4'b0011;
        last = -1;
        for (int n = 0; n < 2; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (grant4 != '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            exp = rr_pick(req4, ptr4_m);
            vectors++;
            if (!ok || active_id4 !== 3'(exp) || tx_data4 !== byte_of(req_data4, exp) || transmission4 !== 1'b1) begin
                miscompares++;
                $display("FAIL stop4_grant%0d: id=%0d byte=%h want id=%0d byte=%h", n, active_id4, tx_data4, exp, byte_of(req_data4, exp));
            end
            if (last >= 0) begin
                vectors++;
                if (cyc - last != 16) begin
                    miscompares++;
                    $display("FAIL stop4_period: got %0d want 16", cyc - last);
                end
            end
            $display("stop4: grant id=%0d period=%0d", active_id4, (last >= 0) ? cyc - last : 0);
            last = cyc;
            ptr4_m = exp;
            req4[exp] = 1'b0;
        end
        req4 = '0;
        repeat (20) tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        stall = 1'b1;
        req_data = {$urandom};
        req = 4'b0100;
        wait_grant(5, ok);
        k = cyc;
        req = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || cyc - k != 32) begin
            miscompares++;
            $display("FAIL timeout_err: err seen=%b at +%0d want +32", ok, cyc - k);
        end
        tick();
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: err=%b busy=%b want 0 0", err, busy);
        end
        $display("timeout: err at +32, busy=%b", busy);
`else
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL no_timeout_hold: err=%b busy=%b want 0 1", err, busy);
        end
        $display("timeout disabled: err=%b busy=%b after 40 ticks", err, busy);
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_random();
        test_reset_mid();
        test_stop4();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
